// File: rtl/imm_extend_queue_if.sv
// ---------------------------------------------------------------------------
// imm_extend_queue_if
// Bundles the producer handshake, the consumer handshake, the redirect flush
// and the occupancy count of imm_extend_queue.
//   flush              : synchronous queue clear (branch/jump redirect)
//   in_valid/in_ready  : decode-side handshake, in_data + in_mode payload
//   out_valid/out_ready: ALU-side handshake, out_data payload (queue head)
//   count              : number of entries held
// Modports: master = the environment driving the unit, slave = the unit.
// ---------------------------------------------------------------------------
interface imm_extend_queue_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [CW-1:0]    count;

    modport master (
        output flush, in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/imm_extend_queue.sv
// ---------------------------------------------------------------------------
// imm_extend_queue
// Immediate-extension unit feeding the ALU operand mux. Each accepted
// immediate is extended (zero / sign / replicate / upper-place) at enqueue
// and stored in a DEPTH-entry circular queue so ALU stalls do not stall
// decode.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high, clears all control state
//   bus   : imm_extend_queue_if.slave (handshakes, flush, count)
// in_mode: 00 zero-extend, 01 sign-extend, 10 replicate bit 0,
//          11 upper-place (lui style).
// ---------------------------------------------------------------------------
module imm_extend_queue #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    imm_extend_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [OUT_W-1:0] word_t;

    word_t          mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    word_t          last_q, last_d;
    logic           push;
    logic           pop;
    word_t          ext_value;

    // Casts avoid zero-width replications when IN_W == OUT_W.
    function automatic word_t extend(input logic [IN_W-1:0] data,
                                     input logic [1:0]      mode);
        logic signed [IN_W-1:0]  sdata;
        logic signed [OUT_W-1:0] sext;
        word_t                   r;
        sdata = $signed(data);
        sext  = OUT_W'(sdata);
        case (mode)
            2'b00:   r = OUT_W'(data);
            2'b01:   r = sext;
            2'b10:   r = {OUT_W{data[0]}};
            default: r = OUT_W'(data) << (OUT_W - IN_W);
        endcase
        return r;
    endfunction

    assign ext_value = extend(bus.in_data, bus.in_mode);

    // Handshake outputs depend only on registered count and flush.
    assign bus.in_ready  = (count_q < CW'(DEPTH)) && !bus.flush;
    assign bus.out_valid = (count_q != '0);
    assign bus.count     = count_q;
    // An empty queue shows the last popped value (0 after reset) rather
    // than whatever stale word the read pointer happens to address.
    assign bus.out_data  = bus.out_valid ? mem_q[rd_ptr_q] : last_q;

    always_comb begin
        push     = bus.in_valid && bus.in_ready;
        pop      = bus.out_valid && bus.out_ready && !bus.flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                last_d   = mem_q[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    // Storage is never cleared; count/pointers decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ext_value;
        end
    end
endmodule

// File: tb/tb_imm_extend_queue.sv
// ---------------------------------------------------------------------------
// tb_imm_extend_queue
// Scoreboard bench for imm_extend_queue: a 16->32 bit DEPTH=2 instance and an
// 8->8 bit DEPTH=4 instance. Directed pushes queue their hand-computed
// expected values; per-instance monitors pop and compare on every transfer.
// ---------------------------------------------------------------------------
module tb_imm_extend_queue;
    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    imm_extend_queue_if #(.IN_W(16), .OUT_W(32), .DEPTH(2)) bus32 ();
    imm_extend_queue_if #(.IN_W(8),  .OUT_W(8),  .DEPTH(4)) bus8 ();

    imm_extend_queue #(.IN_W(16), .OUT_W(32), .DEPTH(2)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32)
    );

    imm_extend_queue #(.IN_W(8), .OUT_W(8), .DEPTH(4)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb32[$];
    logic [7:0]  sb8[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: a transfer happens at the next rising edge when these hold.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset && bus32.out_valid && bus32.out_ready && !bus32.flush) begin
            if (sb32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out32 unexpected: got 0x%0h, expected no output", bus32.out_data);
            end else begin
                e = sb32.pop_front();
                check("out32", bus32.out_data, e);
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (!reset && bus8.out_valid && bus8.out_ready && !bus8.flush) begin
            if (sb8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out8 unexpected: got 0x%0h, expected no output", bus8.out_data);
            end else begin
                e = sb8.pop_front();
                check("out8", 32'(bus8.out_data), 32'(e));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves in_valid high so consecutive calls push back-to-back.
    task automatic push32(input logic [15:0] d, input logic [1:0] m, input logic [31:0] exp);
        bit done = 1'b0;
        bus32.in_data  = d;
        bus32.in_mode  = m;
        bus32.in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus32.in_ready) begin
                sb32.push_back(exp);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push32 timeout: in_ready 0, expected 1");
        end
    endtask

    task automatic push8(input logic [7:0] d, input logic [1:0] m, input logic [7:0] exp);
        bit done = 1'b0;
        bus8.in_data  = d;
        bus8.in_mode  = m;
        bus8.in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus8.in_ready) begin
                sb8.push_back(exp);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push8 timeout: in_ready 0, expected 1");
        end
    endtask

    task automatic drain32();
        for (int i = 0; i < 20 && (sb32.size() != 0 || bus32.out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        check("drain32 leftover", 32'(sb32.size()), 32'd0);
        check("drain32 count", 32'(bus32.count), 32'd0);
    endtask

    task automatic drain8();
        for (int i = 0; i < 20 && (sb8.size() != 0 || bus8.out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        check("drain8 leftover", 32'(sb8.size()), 32'd0);
        check("drain8 count", 32'(bus8.count), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus32.flush = 1'b0; bus32.in_valid = 1'b0; bus32.in_data = '0;
        bus32.in_mode = 2'b00; bus32.out_ready = 1'b0;
        bus8.flush = 1'b0; bus8.in_valid = 1'b0; bus8.in_data = '0;
        bus8.in_mode = 2'b00; bus8.out_ready = 1'b0;

        // Reset state
        #1 reset = 1'b1;
        #11;
        check("rst out_valid", 32'(bus32.out_valid), 32'd0);
        check("rst out_data", bus32.out_data, 32'd0);
        check("rst count", 32'(bus32.count), 32'd0);
        check("rst in_ready", 32'(bus32.in_ready), 32'd1);
        check("rst8 count", 32'(bus8.count), 32'd0);
        check("rst8 in_ready", 32'(bus8.in_ready), 32'd1);
        reset = 1'b0;
        cycles(1);

        // Extension modes, streaming
        bus32.out_ready = 1'b1;
        push32(16'h8001, 2'b00, 32'h0000_8001);
        check("latency out_valid", 32'(bus32.out_valid), 32'd1);
        check("latency out_data", bus32.out_data, 32'h0000_8001);
        push32(16'h8001, 2'b01, 32'hFFFF_8001);
        push32(16'h8001, 2'b10, 32'hFFFF_FFFF);
        push32(16'h8001, 2'b11, 32'h8001_0000);
        bus32.in_valid = 1'b0;
        drain32();

        // Back-pressure
        bus32.out_ready = 1'b0;
        push32(16'h0005, 2'b01, 32'h0000_0005);
        push32(16'h7FFF, 2'b00, 32'h0000_7FFF);
        bus32.in_valid = 1'b0;
        check("full count", 32'(bus32.count), 32'd2);
        check("full in_ready", 32'(bus32.in_ready), 32'd0);
        bus32.in_data  = 16'h1234;
        bus32.in_mode  = 2'b00;
        bus32.in_valid = 1'b1;
        cycles(2);
        check("full third rejected", 32'(bus32.count), 32'd2);
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        @(negedge clk);
        check("full in_ready before pop", 32'(bus32.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("in_ready after first pop", 32'(bus32.in_ready), 32'd1);
        check("count after first pop", 32'(bus32.count), 32'd1);
        drain32();

        // Simultaneous push and pop at count=1, pointers wrap
        bus32.out_ready = 1'b0;
        push32(16'h0100, 2'b00, 32'h0000_0100);
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus32.in_data  = 16'h0101 + 16'(i);
            bus32.in_mode  = 2'b00;
            bus32.in_valid = 1'b1;
            @(negedge clk);
            check("pushpop count", 32'(bus32.count), 32'd1);
            check("pushpop in_ready", 32'(bus32.in_ready), 32'd1);
            sb32.push_back(32'h0000_0101 + 32'(i));
            @(posedge clk);
            #1;
        end
        bus32.in_valid = 1'b0;
        check("pushpop final count", 32'(bus32.count), 32'd1);
        drain32();
        check("empty holds last popped", bus32.out_data, 32'h0000_0108);

        // Flush with a same-cycle push
        bus32.out_ready = 1'b0;
        push32(16'h00AA, 2'b00, 32'h0000_00AA);
        push32(16'h00BB, 2'b01, 32'h0000_00BB);
        bus32.in_valid = 1'b0;
        check("preflush count", 32'(bus32.count), 32'd2);
        bus32.flush    = 1'b1;
        bus32.in_data  = 16'hDEAD;
        bus32.in_mode  = 2'b00;
        bus32.in_valid = 1'b1;
        @(negedge clk);
        check("flush in_ready", 32'(bus32.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus32.flush    = 1'b0;
        bus32.in_valid = 1'b0;
        sb32.delete();
        check("flush count", 32'(bus32.count), 32'd0);
        check("flush out_valid", 32'(bus32.out_valid), 32'd0);
        check("flush out_data", bus32.out_data, 32'h0000_0108);
        bus32.out_ready = 1'b1;
        cycles(3);
        check("flush stays empty", 32'(bus32.count), 32'd0);
        push32(16'h0003, 2'b00, 32'h0000_0003);
        bus32.in_valid = 1'b0;
        drain32();

        // 8-bit, DEPTH=4 instance
        bus8.out_ready = 1'b0;
        push8(8'h80, 2'b01, 8'h80);
        push8(8'h80, 2'b11, 8'h80);
        push8(8'h5A, 2'b00, 8'h5A);
        push8(8'h01, 2'b10, 8'hFF);
        bus8.in_valid = 1'b0;
        check("w8 full count", 32'(bus8.count), 32'd4);
        check("w8 full in_ready", 32'(bus8.in_ready), 32'd0);
        bus8.out_ready = 1'b1;
        drain8();

        // Asynchronous reset mid-stream
        bus32.out_ready = 1'b0;
        push32(16'h0011, 2'b00, 32'h0000_0011);
        push32(16'h0022, 2'b00, 32'h0000_0022);
        bus32.in_valid = 1'b0;
        check("prereset count", 32'(bus32.count), 32'd2);
        #2 reset = 1'b1;
        #1;
        check("async rst out_valid", 32'(bus32.out_valid), 32'd0);
        check("async rst count", 32'(bus32.count), 32'd0);
        check("async rst out_data", bus32.out_data, 32'd0);
        check("async rst in_ready", 32'(bus32.in_ready), 32'd1);
        sb32.delete();
        bus32.in_data   = 16'h0055;
        bus32.in_mode   = 2'b00;
        bus32.in_valid  = 1'b1;
        bus32.out_ready = 1'b1;
        cycles(1);
        check("push ignored in reset", 32'(bus32.count), 32'd0);
        bus32.in_valid = 1'b0;
        #2 reset = 1'b0;
        cycles(1);
        push32(16'h0001, 2'b10, 32'hFFFF_FFFF);
        bus32.in_valid = 1'b0;
        drain32();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
